uart_msg_sender: RTL and testbench

Parametrised message source for the UART transmitter. It holds a MSG_DEPTH-entry byte buffer that the host loads through a write port, and sends the first msg_len entries in order to the TX core. Each byte is sent with a programmable inter-byte gap and a valid/busy handshake. Supports one-shot and repeating transmission. Sits between board control logic and the UART TX core.

---
 rtl/uart_msg_sender.sv | 136 +++++++++++++
 tb/tb_uart_msg_sender.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_msg_sender.sv
// uart_msg_sender: buffered message source feeding the UART TX core, one word at a time with a fixed pre-word gap.
// Define UART_MSG_SENDER_CRLF_EN to append a 0x0D/0x0A trailer to every pass.
module uart_msg_sender #(
  parameter int DATA_W     = 8,
  parameter int MSG_DEPTH  = 16,
  parameter int GAP_CYCLES = 8,
  parameter int LEN_W      = $clog2(MSG_DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         wr_en,
  input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [LEN_W-1:0]             msg_len,
  input  logic                         start,
  input  logic                         repeat_en,
  input  logic                         tx_busy,
  output logic [DATA_W-1:0]            tx_data,
  output logic                         tx_valid,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(MSG_DEPTH)-1:0] byte_idx
);
  localparam int IDX_W = $clog2(MSG_DEPTH);
  localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(MSG_DEPTH);

  // states: IDLE wait start | LOAD fetch word | GAP pre-word delay | SEND offer word | DRAIN wait TX idle
  typedef enum logic [2:0] {IDLE, LOAD, GAP, SEND, DRAIN} state_t;

  state_t             state;
  logic [DATA_W-1:0]  msg_buf [MSG_DEPTH];
  logic [CNT_W-1:0]   gap_cnt;
  logic [LEN_W-1:0]   len;
  logic               armed;
  logic               last_word;
`ifdef UART_MSG_SENDER_CRLF_EN
  logic [1:0]         trl;
`endif

  assign busy      = (state != IDLE);
  assign last_word = ((LEN_W'(byte_idx) + LEN_W'(1)) == len);

  always_ff @(posedge clk) begin
    if (wr_en && state == IDLE) msg_buf[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      done     <= 1'b0;
      byte_idx <= '0;
      gap_cnt  <= '0;
      len      <= '0;
      armed    <= 1'b0;
`ifdef UART_MSG_SENDER_CRLF_EN
      trl      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && msg_len != '0) begin
            len      <= (msg_len > DEPTH_LEN) ? DEPTH_LEN : msg_len;
            byte_idx <= '0;
            state    <= LOAD;
          end
        end
        LOAD: begin
`ifdef UART_MSG_SENDER_CRLF_EN
          case (trl)
            2'd0:    tx_data <= msg_buf[byte_idx];
            2'd1:    tx_data <= DATA_W'(8'h0D);
            default: tx_data <= DATA_W'(8'h0A);
          endcase
`else
          tx_data <= msg_buf[byte_idx];
`endif
          gap_cnt <= '0;
          armed   <= 1'b0;
          if (GAP_CYCLES > 0) begin
            state <= GAP;
          end else begin
            state    <= SEND;
            tx_valid <= 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state    <= SEND;
            tx_valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + CNT_W'(1);
          end
        end
        // A busy level already present on entry belongs to someone else; only a fresh rise means acceptance.
        SEND: begin
          if (!tx_busy) begin
            armed <= 1'b1;
          end else if (armed) begin
            tx_valid <= 1'b0;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (!tx_busy) begin
            state <= LOAD;
            if (!last_word) begin
              byte_idx <= byte_idx + IDX_W'(1);
            end
`ifdef UART_MSG_SENDER_CRLF_EN
            else if (trl != 2'd2) begin
              trl <= trl + 2'd1;
            end
`endif
            else begin
`ifdef UART_MSG_SENDER_CRLF_EN
              trl <= '0;
`endif
              if (repeat_en) begin
                byte_idx <= '0;
              end else begin
                done  <= 1'b1;
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_msg_sender.sv
// Directed self-checking bench for uart_msg_sender: main instance with an 8-cycle gap, second instance with no gap.
`timescale 1ns/1ps
module tb_uart_msg_sender;
  localparam int DW = 8, DEPTH = 16, IW = 4, LW = 5;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [LW-1:0] msg_len = '0;
  logic          start = 1'b0;
  logic          repeat_en = 1'b0;
  logic          tx_busy;
  logic [DW-1:0] tx_data;
  logic          tx_valid, busy, done;
  logic [IW-1:0] byte_idx;

  logic          wr_en0 = 1'b0;
  logic [IW-1:0] wr_addr0 = '0;
  logic [DW-1:0] wr_data0 = '0;
  logic [LW-1:0] msg_len0 = '0;
  logic          start0 = 1'b0;
  logic          tx_busy0 = 1'b0;
  logic [DW-1:0] tx_data0;
  logic          tx_valid0, busy0, done0;
  logic [IW-1:0] byte_idx0;

  uart_msg_sender #(.DATA_W(DW), .MSG_DEPTH(DEPTH), .GAP_CYCLES(8)) dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .start(start), .repeat_en(repeat_en), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy), .done(done), .byte_idx(byte_idx));

  uart_msg_sender #(.DATA_W(DW), .MSG_DEPTH(DEPTH), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .resetn(resetn), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .msg_len(msg_len0), .start(start0), .repeat_en(1'b0), .tx_busy(tx_busy0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .busy(busy0), .done(done0), .byte_idx(byte_idx0));

  // TX core model: takes a word when valid and idle, then stays busy for busy_len cycles.
  int   bcnt = 0;
  int   busy_len = 20;
  logic force_busy = 1'b0;
  always @(posedge clk) begin
    if (!resetn)                          bcnt <= 0;
    else if (bcnt != 0)                   bcnt <= bcnt - 1;
    else if (tx_valid && !force_busy)     bcnt <= busy_len;
  end
  assign tx_busy = (bcnt != 0) || force_busy;

  logic [DW-1:0] q_data[$];
  int            q_gap[$];
  int            idle_run = 0, done_cnt = 0, done_busy_err = 0, stable_err = 0;
  logic          prev_valid = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (tx_valid && !prev_valid) begin
      q_data.push_back(tx_data);
      q_gap.push_back(idle_run);
    end
    if (tx_valid && prev_valid && tx_data != prev_data) stable_err++;
    if (busy && !tx_valid && !tx_busy) idle_run++;
    else                               idle_run = 0;
    if (done) begin
      done_cnt++;
      if (busy) done_busy_err++;
    end
    prev_valid = tx_valid;
    prev_data  = tx_data;
  end

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [DW-1:0] data);
    wr_en = 1'b1; wr_addr = IW'(addr); wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start_msg(input int len);
    msg_len = LW'(len); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_rec();
    q_data.delete(); q_gap.delete();
    done_cnt = 0; done_busy_err = 0; stable_err = 0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (busy && n < max) begin tick(); n++; end
    check(tag, busy, 0);
  endtask

  task automatic wait_valid(input string tag, input int max);
    int n = 0;
    while (!tx_valid && n < max) begin tick(); n++; end
    check(tag, tx_valid, 1);
  endtask

  task automatic wait_words(input string tag, input int cnt, input int max);
    int n = 0;
    while (q_data.size() < cnt && n < max) begin tick(); n++; end
    check(tag, (q_data.size() >= cnt), 1);
  endtask

  initial begin
    int errs;
    logic saw_busy;
    repeat (2) tick();
    resetn = 1'b1;
    tick();

    // reset while parked in SEND
    wr(0, 8'h41); wr(1, 8'h42); wr(2, 8'h43);
    clear_rec();
    force_busy = 1'b1;
    start_msg(3);
    wait_valid("rst_reach_send", 50);
    resetn = 1'b0;
    tick();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_byte_idx", byte_idx, 0);
    check("rst_done", done, 0);
    check("rst_tx_data", tx_data, 0);
    resetn = 1'b1;
    force_busy = 1'b0;
    repeat (5) tick();
    check("rst_stays_idle", busy, 0);
    check("rst_no_done", done_cnt, 0);

    // three-word one-shot, 20-cycle TX busy; gap run is LOAD+8 GAP, plus the drain-exit cycle after the first word
    clear_rec();
    busy_len = 20;
    repeat_en = 1'b0;
    start_msg(3);
    wait_idle("abc_timeout", 1000);
    check("abc_count", q_data.size(), 3);
    check("abc_w0", q_data[0], 8'h41);
    check("abc_w1", q_data[1], 8'h42);
    check("abc_w2", q_data[2], 8'h43);
    check("abc_gap0", q_gap[0], 9);
    check("abc_gap1", q_gap[1], 10);
    check("abc_gap2", q_gap[2], 10);
    check("abc_done_cnt", done_cnt, 1);
    check("abc_done_busy", done_busy_err, 0);
    check("abc_stable", stable_err, 0);

    // zero-gap instance: valid in the cycle after edge k+1
    wr_en0 = 1'b1; wr_addr0 = '0; wr_data0 = 8'h5A;
    tick();
    wr_en0 = 1'b0;
    msg_len0 = LW'(1); start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("gap0_load_valid", tx_valid0, 0);
    check("gap0_load_busy", busy0, 1);
    tick();
    check("gap0_valid", tx_valid0, 1);
    check("gap0_data", tx_data0, 8'h5A);

    // msg_len=0 is ignored
    clear_rec();
    saw_busy = 1'b0;
    start_msg(0);
    for (int i = 0; i < 20; i++) begin
      saw_busy |= busy;
      tick();
    end
    check("len0_busy", saw_busy, 0);
    check("len0_words", q_data.size(), 0);
    check("len0_done", done_cnt, 0);

    // msg_len=31 clamps to 16 words
    for (int i = 0; i < DEPTH; i++) wr(i, DW'(8'h10 + i));
    clear_rec();
    busy_len = 2;
    start_msg(31);
    wait_idle("len31_timeout", 1000);
    check("len31_count", q_data.size(), 16);
    errs = 0;
    for (int i = 0; i < q_data.size(); i++) if (q_data[i] !== DW'(8'h10 + i)) errs++;
    check("len31_data_errs", errs, 0);
    check("len31_last", q_data[15], 8'h1F);
    check("len31_done", done_cnt, 1);

    // repeat mode, then drop repeat_en during word 0 of the third pass
    wr(0, 8'hA0); wr(1, 8'hA1);
    clear_rec();
    busy_len = 4;
    repeat_en = 1'b1;
    start_msg(2);
    wait_words("rep_timeout", 5, 500);
    check("rep_w0", q_data[0], 8'hA0);
    check("rep_w1", q_data[1], 8'hA1);
    check("rep_w2", q_data[2], 8'hA0);
    check("rep_w3", q_data[3], 8'hA1);
    check("rep_w4", q_data[4], 8'hA0);
    check("rep_wrap_gap", q_gap[2], 10);
    check("rep_no_done", done_cnt, 0);
    check("rep_busy", busy, 1);
    repeat_en = 1'b0;
    wait_idle("rep_stop_timeout", 500);
    check("rep_stop_count", q_data.size(), 6);
    check("rep_stop_last", q_data[5], 8'hA1);
    check("rep_stop_done", done_cnt, 1);

    // tx_busy already high on SEND entry; write during transmission must be dropped
    clear_rec();
    force_busy = 1'b1;
    start_msg(1);
    wr(0, 8'h99);
    wait_valid("held_reach_send", 50);
    repeat (30) tick();
    check("held_valid", tx_valid, 1);
    check("held_data", tx_data, 8'hA0);
    force_busy = 1'b0;
    tick();
    check("held_valid_after_fall", tx_valid, 1);
    tick();
    check("held_accept", tx_valid, 0);
    wait_idle("held_timeout", 200);
    check("held_done", done_cnt, 1);

    clear_rec();
    start_msg(1);
    wait_idle("readback_timeout", 200);
    check("readback_count", q_data.size(), 1);
    check("readback_data", q_data[0], 8'hA0);
    check("final_stable", stable_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
